// File: rtl/vga_timing.sv
// vga_timing: raster position counters with registered sync/blank strobes and a frame-start pulse.
//   clk          pixel clock, rising edge
//   rst          asynchronous active-low reset
//   hcount_out   current pixel 0..H_TOTAL-1
//   vcount_out   current line 0..V_TOTAL-1
//   hsync_out    horizontal sync, SYNC_ACTIVE inside the sync window
//   vsync_out    vertical sync, SYNC_ACTIVE inside the sync window
//   hblnk_out    1 outside the active pixels
//   vblnk_out    1 outside the active lines
//   frame_start  one-cycle pulse when the raster wraps to (0,0)
module vga_timing #(
    parameter int   H_ACTIVE    = 1024,
    parameter int   H_FP        = 24,
    parameter int   H_SYNC      = 136,
    parameter int   H_BP        = 160,
    parameter int   V_ACTIVE    = 768,
    parameter int   V_FP        = 3,
    parameter int   V_SYNC      = 6,
    parameter int   V_BP        = 29,
    parameter logic SYNC_ACTIVE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] vcount_out,
    output logic [10:0] hcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_BLNK = 11'(H_ACTIVE);
    localparam logic [10:0] H_SS   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SE   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_BLNK = 11'(V_ACTIVE);
    localparam logic [10:0] V_SS   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SE   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    generate
        if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_totals
            $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 2048");
        end
    endgenerate

    logic [10:0] r_h, r_v;
    logic        r_hsync, r_vsync, r_hblnk, r_vblnk, r_fs;
    logic        w_h_wrap;
    logic [10:0] w_h_next, w_v_next;

    // Out-of-range counts (e.g. upsets) also take the wrap path, so they clear on the next edge.
    always_comb begin
        w_h_wrap = r_h >= H_LAST;
        w_h_next = w_h_wrap ? 11'd0 : r_h + 11'd1;
        w_v_next = (r_v > V_LAST) ? 11'd0 :
                   !w_h_wrap      ? r_v   :
                   (r_v == V_LAST) ? 11'd0 : r_v + 11'd1;
    end

    // Strobes are decoded from the next count so they land in the same cycle as the count they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h     <= '0;
            r_v     <= '0;
            r_hblnk <= 1'b0;
            r_vblnk <= 1'b0;
            r_hsync <= ~SYNC_ACTIVE;
            r_vsync <= ~SYNC_ACTIVE;
            r_fs    <= 1'b0;
        end else begin
            r_h     <= w_h_next;
            r_v     <= w_v_next;
            r_hblnk <= w_h_next >= H_BLNK;
            r_vblnk <= w_v_next >= V_BLNK;
            r_hsync <= (w_h_next >= H_SS && w_h_next <= H_SE) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vsync <= (w_v_next >= V_SS && w_v_next <= V_SE) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_fs    <= w_h_next == 11'd0 && w_v_next == 11'd0;
        end
    end

    assign hcount_out  = r_h;
    assign vcount_out  = r_v;
    assign hblnk_out   = r_hblnk;
    assign vblnk_out   = r_vblnk;
    assign hsync_out   = r_hsync;
    assign vsync_out   = r_vsync;
    assign frame_start = r_fs;
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed checks of vga_timing at default, reduced-vertical, tiny and inverted-polarity settings.
module tb_vga_timing;
    localparam int HT = 1344;
    localparam int FR = HT * 14;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n = 0;

    logic [10:0] d_h, d_v, m_h, m_v, s_h, s_v, p_h, p_v;
    logic d_hs, d_vs, d_hb, d_vb, d_fs;
    logic m_hs, m_vs, m_hb, m_vb, m_fs;
    logic s_hs, s_vs, s_hb, s_vb, s_fs;
    logic p_hs, p_vs, p_hb, p_vb, p_fs;

    vga_timing u_def (
        .clk(clk), .rst(rst), .vcount_out(d_v), .hcount_out(d_h), .vsync_out(d_vs),
        .vblnk_out(d_vb), .hsync_out(d_hs), .hblnk_out(d_hb), .frame_start(d_fs)
    );
    vga_timing #(.V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_mid (
        .clk(clk), .rst(rst), .vcount_out(m_v), .hcount_out(m_h), .vsync_out(m_vs),
        .vblnk_out(m_vb), .hsync_out(m_hs), .hblnk_out(m_hb), .frame_start(m_fs)
    );
    vga_timing #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                 .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_small (
        .clk(clk), .rst(rst), .vcount_out(s_v), .hcount_out(s_h), .vsync_out(s_vs),
        .vblnk_out(s_vb), .hsync_out(s_hs), .hblnk_out(s_hb), .frame_start(s_fs)
    );
    vga_timing #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                 .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_ACTIVE(1'b0)) u_pol (
        .clk(clk), .rst(rst), .vcount_out(p_v), .hcount_out(p_h), .vsync_out(p_vs),
        .vblnk_out(p_vb), .hsync_out(p_hs), .hblnk_out(p_hb), .frame_start(p_fs)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
        n += k;
    endtask

    task automatic step_to(input int t);
        step(t - n);
    endtask

    initial begin
        int eh, ev, vs_cnt, fs_cnt, d_fs_cnt, fs_first, fs_second, dbl;
        logic fs_prev;
        vs_cnt = 0; fs_cnt = 0; d_fs_cnt = 0; fs_first = -1; fs_second = -1; dbl = 0; fs_prev = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_h", 32'(d_h), 0);
        chk("rst_v", 32'(d_v), 0);
        chk("rst_hb", 32'(d_hb), 0);
        chk("rst_vb", 32'(d_vb), 0);
        chk("rst_hs", 32'(d_hs), 0);
        chk("rst_vs", 32'(d_vs), 0);
        chk("rst_fs", 32'(d_fs), 0);
        chk("rst_pol_hs", 32'(p_hs), 1);
        chk("rst_pol_vs", 32'(p_vs), 1);
        rst = 1'b1;
        n = 0;
        for (int i = 0; i <= 150; i++) begin
            eh = n % 8;
            ev = (n / 8) % 6;
            chk("small_h", 32'(s_h), 32'(eh));
            chk("small_v", 32'(s_v), 32'(ev));
            chk("small_hb", 32'(s_hb), 32'(eh >= 4));
            chk("small_vb", 32'(s_vb), 32'(ev >= 3));
            chk("small_hs", 32'(s_hs), 32'(eh >= 5 && eh <= 6));
            chk("small_vs", 32'(s_vs), 32'(ev == 4));
            chk("small_fs", 32'(s_fs), 32'(n > 0 && eh == 0 && ev == 0));
            chk("pol_hs", 32'(p_hs), 32'(!(eh >= 5 && eh <= 6)));
            chk("pol_vs", 32'(p_vs), 32'(ev != 4));
            chk("pol_hb", 32'(p_hb), 32'(eh >= 4));
            chk("pol_vb", 32'(p_vb), 32'(ev >= 3));
            chk("def_h", 32'(d_h), 32'(n));
            chk("def_v", 32'(d_v), 0);
            chk("def_fs", 32'(d_fs), 0);
            step(1);
        end
        step_to(1023);
        chk("h1023_hb", 32'(d_hb), 0);
        chk("h1023_hs", 32'(d_hs), 0);
        step_to(1024);
        chk("h1024_hb", 32'(d_hb), 1);
        chk("h1024_hs", 32'(d_hs), 0);
        step_to(1047);
        chk("h1047_hs", 32'(d_hs), 0);
        step_to(1048);
        chk("h1048_hs", 32'(d_hs), 1);
        step_to(1183);
        chk("h1183_hs", 32'(d_hs), 1);
        step_to(1184);
        chk("h1184_hs", 32'(d_hs), 0);
        chk("h1184_hb", 32'(d_hb), 1);
        step_to(1343);
        chk("h1343_h", 32'(d_h), 1343);
        chk("h1343_v", 32'(d_v), 0);
        step_to(1344);
        chk("hwrap_h", 32'(d_h), 0);
        chk("hwrap_v", 32'(d_v), 1);
        chk("hwrap_hb", 32'(d_hb), 0);
        chk("hwrap_fs", 32'(d_fs), 0);
        while (n <= 2 * FR + 2) begin
            if (m_vs && n < FR) vs_cnt++;
            if (m_fs) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = n;
                else if (fs_second < 0) fs_second = n;
            end
            if (m_fs && fs_prev) dbl++;
            fs_prev = m_fs;
            if (d_fs) d_fs_cnt++;
            if (n == 10 * HT - 1) begin
                chk("v9_v", 32'(m_v), 9);
                chk("v9_vb", 32'(m_vb), 0);
            end
            if (n == 10 * HT) begin
                chk("v10_v", 32'(m_v), 10);
                chk("v10_h", 32'(m_h), 0);
                chk("v10_vb", 32'(m_vb), 1);
            end
            if (n == 11 * HT - 1) chk("vs_pre", 32'(m_vs), 0);
            if (n == 11 * HT) chk("vs_rise", 32'(m_vs), 1);
            if (n == 13 * HT - 1) chk("vs_last", 32'(m_vs), 1);
            if (n == 13 * HT) chk("vs_fall", 32'(m_vs), 0);
            if (n == FR - 1) begin
                chk("vlast_h", 32'(m_h), 1343);
                chk("vlast_v", 32'(m_v), 13);
                chk("vlast_vb", 32'(m_vb), 1);
                chk("vlast_fs", 32'(m_fs), 0);
            end
            if (n == FR) begin
                chk("vwrap_h", 32'(m_h), 0);
                chk("vwrap_v", 32'(m_v), 0);
                chk("vwrap_vb", 32'(m_vb), 0);
                chk("vwrap_fs", 32'(m_fs), 1);
            end
            if (n == FR + 1) chk("fs_width", 32'(m_fs), 0);
            step(1);
        end
        chk("vsync_cycles", 32'(vs_cnt), 2 * HT);
        chk("fs_count", 32'(fs_cnt), 2);
        chk("fs_first", 32'(fs_first), FR);
        chk("fs_period", 32'(fs_second - fs_first), FR);
        chk("fs_double", 32'(dbl), 0);
        chk("def_no_fs", 32'(d_fs_cnt), 0);
        while (n % HT != 500) step(1);
        chk("pre_rst_h", 32'(d_h), 500);
        chk("pre_rst_v", 32'(d_v), 32'(n / HT));
        #1 rst = 1'b0;
        #1;
        chk("async_h", 32'(d_h), 0);
        chk("async_v", 32'(d_v), 0);
        chk("async_hb", 32'(d_hb), 0);
        chk("async_hs", 32'(d_hs), 0);
        chk("async_pol_hs", 32'(p_hs), 1);
        chk("async_mid_v", 32'(m_v), 0);
        repeat (5) @(negedge clk);
        chk("held_h", 32'(d_h), 0);
        chk("held_v", 32'(d_v), 0);
        rst = 1'b1;
        n = 0;
        chk("rel_h", 32'(d_h), 0);
        chk("rel_fs", 32'(d_fs), 0);
        step(1);
        chk("rel1_h", 32'(d_h), 1);
        chk("rel1_v", 32'(d_v), 0);
        chk("rel1_fs", 32'(d_fs), 0);
        step(1);
        chk("rel2_h", 32'(d_h), 2);
        step_to(8);
        chk("rel_small_h", 32'(s_h), 0);
        chk("rel_small_v", 32'(s_v), 1);
        chk("rel_small_fs", 32'(s_fs), 0);
        step_to(48);
        chk("rel_small_wrap_fs", 32'(s_fs), 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
